// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Snapshot bit index is col*4+row; key_code is {row, col}.
package keypad_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  localparam int NUM_KEYS = NUM_COLS * NUM_ROWS;

  localparam int CODE_W       = 4;
  localparam int CODE_FIELD_W = 2;
  localparam int CODE_COL_LSB = 0;
  localparam int CODE_ROW_LSB = 2;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    HELD,
    REL
  } kp_state_e;

  function automatic logic [CODE_W-1:0] idx_to_code(
    input logic [CODE_W-1:0] idx
  );
    logic [CODE_W-1:0] code;
    code = '0;
    code[CODE_ROW_LSB +: CODE_FIELD_W] = idx[1:0];
    code[CODE_COL_LSB +: CODE_FIELD_W] = idx[3:2];
    return code;
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Key-event handshake between the scanner and the datapath.
// Also carries the sticky overrun flag.
interface keypad_if;
  import keypad_pkg::*;

  logic              key_valid;
  logic [CODE_W-1:0] key_code;
  logic              key_ready;
  logic              overrun;

  modport master (
    output key_valid,
    output key_code,
    output overrun,
    input  key_ready
  );

  modport slave (
    input  key_valid,
    input  key_code,
    input  overrun,
    output key_ready
  );

endinterface

// File: rtl/row_sync.sv
// Two-flop synchronizer for the asynchronous row inputs.
// Resets to all-ones, matching the board pull-ups.
module row_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with per-scan debounce and a
// valid/ready event register with sticky overrun.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  output logic [3:0]    col_out,
  input  logic [3:0]    row_in,
  keypad_if.master      kp
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [3:0]          row_s;
  logic [1:0]          col;
  logic [DW-1:0]       div;
  logic [NUM_KEYS-1:0] snap;
  logic                last_slot;
  logic                end_scan;

  row_sync #(.W(NUM_ROWS)) u_sync (
    .clk   (Clk),
    .rst_n (Reset),
    .d     (row_in),
    .q     (row_s)
  );

  assign last_slot = (div == DIV_LAST);
  assign end_scan  = last_slot && (col == 2'd3);
  assign col_out   = ~(4'b0001 << col);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      col  <= '0;
      div  <= '0;
      snap <= '0;
    end else if (last_slot) begin
      div  <= '0;
      col  <= col + 2'd1;
      snap[{col, 2'b00} +: 4] <= ~row_s;
    end else begin
      div  <= div + DW'(1);
    end
  end

  // Column 3 is sampled in the same cycle it is classified.
  logic [NUM_KEYS-1:0] scan_bits;
  logic [4:0]          n_set;
  logic [3:0]          hit_idx;
  logic [CODE_W-1:0]   hit_code;
  logic                is_none;
  logic                is_single;

  always_comb begin
    scan_bits        = snap;
    scan_bits[15:12] = ~row_s;
    n_set            = '0;
    hit_idx          = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (scan_bits[i]) begin
        n_set   = n_set + 5'd1;
        hit_idx = 4'(i);
      end
    end
  end

  assign hit_code  = idx_to_code(hit_idx);
  assign is_none   = (n_set == 5'd0);
  assign is_single = (n_set == 5'd1);

  kp_state_e         state, state_n;
  logic [CW-1:0]     cnt, cnt_n, cnt_inc;
  logic [CODE_W-1:0] cand, cand_n;
  logic              emit;
  logic              match;

  assign match   = is_single && (hit_code == cand);
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cand  <= cand_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    emit    = 1'b0;
    if (end_scan) begin
      unique case (state)
        IDLE: begin
          if (is_single) begin
            cand_n = hit_code;
            cnt_n  = CNT_ONE;
            if (DEBOUNCE_SCANS == 1) begin
              emit    = 1'b1;
              state_n = HELD;
            end else begin
              state_n = PEND;
            end
          end
        end
        PEND: begin
          if (match) begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              emit    = 1'b1;
              state_n = HELD;
            end
          end else if (is_single) begin
            cand_n = hit_code;
            cnt_n  = CNT_ONE;
          end else begin
            state_n = IDLE;
          end
        end
        HELD: begin
          if (!match) begin
            cnt_n   = CNT_ONE;
            state_n = REL;
          end
        end
        REL: begin
          if (is_none) begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_MAX) state_n = IDLE;
          end else if (match) begin
            state_n = HELD;
          end else begin
            cnt_n = CNT_ONE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  logic              valid_q;
  logic [CODE_W-1:0] code_q;
  logic              ovr_q;
  logic              accept;

  assign accept = valid_q && kp.key_ready;

  // A pending event that is not being accepted makes a new one drop.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      valid_q <= 1'b0;
      code_q  <= '0;
      ovr_q   <= 1'b0;
    end else if (emit && (!valid_q || kp.key_ready)) begin
      valid_q <= 1'b1;
      code_q  <= cand_n;
      ovr_q   <= 1'b0;
    end else if (emit) begin
      ovr_q   <= 1'b1;
    end else if (accept) begin
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end
  end

  assign kp.key_valid = valid_q;
  assign kp.key_code  = code_q;
  assign kp.overrun   = ovr_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4 and
// DEBOUNCE_SCANS=2 (16-cycle scan) and a keypad model.
module tb_keypad_scanner;

  logic        clk;
  logic        rst_n;
  logic [3:0]  col_out;
  logic [3:0]  row_in;
  logic [15:0] keys;
  int          errors;
  int          checks;
  int          rises;

  keypad_if kp ();

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (2)
  ) dut (
    .Clk     (clk),
    .Reset   (rst_n),
    .col_out (col_out),
    .row_in  (row_in),
    .kp      (kp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Key at bit c*4+r pulls row r low while column c is driven.
  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c*4+r] && !col_out[c]) row_in[r] = 1'b0;
  end

  localparam logic [15:0] K00 = 16'h0001;
  localparam logic [15:0] K01 = 16'h0010;
  localparam logic [15:0] K12 = 16'h0200;
  localparam logic [15:0] K21 = 16'h0040;
  localparam logic [15:0] K33 = 16'h8000;

  task automatic do_reset();
    rst_n        = 1'b0;
    keys         = '0;
    kp.key_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic scan(input logic [15:0] k,
                      input bit rf = 1'b0,
                      input bit rl = 1'b0);
    logic pv;
    keys = k;
    pv   = kp.key_valid;
    for (int i = 0; i < 16; i++) begin
      kp.key_ready = (rf && i == 0) || (rl && i == 15);
      @(negedge clk);
      if (kp.key_valid && !pv) rises++;
      pv = kp.key_valid;
    end
    kp.key_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    rst_n        = 1'b0;
    keys         = '0;
    kp.key_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (col_out !== 4'b1110) begin
      errors++;
      $display("FAIL rst_col got %b want 1110", col_out);
    end
    checks++;
    if (kp.key_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got %b want 0", kp.key_valid);
    end
    checks++;
    if (kp.key_code !== 4'h0) begin
      errors++;
      $display("FAIL rst_code got %h want 0", kp.key_code);
    end
    checks++;
    if (kp.overrun !== 1'b0) begin
      errors++;
      $display("FAIL rst_ovr got %b want 0", kp.overrun);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      exp = 4'b0001 << ((i / 4) % 4);
      exp = ~exp;
      checks++;
      if (col_out !== exp) begin
        errors++;
        $display("FAIL col_seq[%0d] got %b want %b",
                 i, col_out, exp);
      end
      @(negedge clk);
    end
    checks++;
    if (kp.key_valid !== 1'b0 || kp.overrun !== 1'b0) begin
      errors++;
      $display("FAIL idle_flags got %b%b want 00",
               kp.key_valid, kp.overrun);
    end
  endtask

  task automatic test_single();
    do_reset();
    keys = K21;
    repeat (16) @(negedge clk);
    repeat (15) @(negedge clk);
    checks++;
    if (kp.key_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early got %b want 0", kp.key_valid);
    end
    @(negedge clk);
    checks++;
    if (kp.key_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_valid got %b want 1", kp.key_valid);
    end
    checks++;
    if (kp.key_code !== 4'b1001) begin
      errors++;
      $display("FAIL single_code got %b want 1001", kp.key_code);
    end
    kp.key_ready = 1'b1;
    @(negedge clk);
    kp.key_ready = 1'b0;
    checks++;
    if (kp.key_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_accept got %b want 0", kp.key_valid);
    end
    repeat (15) @(negedge clk);
    rises = 0;
    scan(K21);
    scan(K21);
    scan('0);
    scan('0);
    checks++;
    if (rises !== 0) begin
      errors++;
      $display("FAIL no_repeat got %0d want 0", rises);
    end
    scan(K21);
    scan(K21);
    checks++;
    if (rises !== 1 || kp.key_code !== 4'b1001) begin
      errors++;
      $display("FAIL repress got %0d/%b want 1/1001",
               rises, kp.key_code);
    end
  endtask

  task automatic test_bounce();
    do_reset();
    rises = 0;
    scan(K00);
    scan('0);
    scan(K00);
    checks++;
    if (kp.key_valid !== 1'b0) begin
      errors++;
      $display("FAIL bounce_early got %b want 0", kp.key_valid);
    end
    scan(K00);
    checks++;
    if (rises !== 1 || kp.key_code !== 4'h0) begin
      errors++;
      $display("FAIL bounce_event got %0d/%h want 1/0",
               rises, kp.key_code);
    end
    scan(K00, 1'b1);
    checks++;
    if (kp.key_valid !== 1'b0) begin
      errors++;
      $display("FAIL bounce_accept got %b want 0", kp.key_valid);
    end
    scan('0);
    scan(K00);
    scan(K00);
    scan('0);
    scan('0);
    checks++;
    if (rises !== 1 || kp.key_valid !== 1'b0) begin
      errors++;
      $display("FAIL short_release got %0d/%b want 1/0",
               rises, kp.key_valid);
    end
  endtask

  task automatic test_multi();
    do_reset();
    rises = 0;
    repeat (4) scan(K00 | K33);
    checks++;
    if (rises !== 0) begin
      errors++;
      $display("FAIL multi_none got %0d want 0", rises);
    end
    scan(K00);
    checks++;
    if (kp.key_valid !== 1'b0) begin
      errors++;
      $display("FAIL multi_early got %b want 0", kp.key_valid);
    end
    scan(K00);
    checks++;
    if (rises !== 1 || kp.key_code !== 4'h0) begin
      errors++;
      $display("FAIL multi_event got %0d/%h want 1/0",
               rises, kp.key_code);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    scan(K01);
    scan(K01);
    checks++;
    if (kp.key_valid !== 1'b1 || kp.key_code !== 4'b0001) begin
      errors++;
      $display("FAIL ovr_first got %b/%b want 1/0001",
               kp.key_valid, kp.key_code);
    end
    scan('0);
    scan('0);
    scan(K12);
    scan(K12);
    checks++;
    if (kp.key_code !== 4'b0001 || kp.overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_drop got %b/%b want 0001/1",
               kp.key_code, kp.overrun);
    end
    scan(K12, 1'b1);
    checks++;
    if (kp.key_valid !== 1'b0 || kp.overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear got %b%b want 00",
               kp.key_valid, kp.overrun);
    end
    scan('0);
    scan('0);
    scan(K01);
    scan(K01);
    scan('0);
    scan('0);
    scan(K01);
    scan(K01);
    checks++;
    if (kp.overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_again got %b want 1", kp.overrun);
    end
    scan('0);
    scan('0);
    scan(K12);
    scan(K12, 1'b0, 1'b1);
    checks++;
    if (kp.key_valid !== 1'b1 || kp.key_code !== 4'b0110 ||
        kp.overrun !== 1'b0) begin
      errors++;
      $display("FAIL emit_accept got %b/%b/%b want 1/0110/0",
               kp.key_valid, kp.key_code, kp.overrun);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp;
    do_reset();
    scan(K21);
    scan(K21);
    scan('0);
    scan('0);
    scan(K01);
    keys = K01;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (col_out !== 4'b1110 || kp.key_valid !== 1'b0 ||
        kp.key_code !== 4'h0 || kp.overrun !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst got %b/%b/%h/%b want 1110/0/0/0",
               col_out, kp.key_valid, kp.key_code, kp.overrun);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp = 4'b0001 << (i / 4);
      exp = ~exp;
      checks++;
      if (col_out !== exp) begin
        errors++;
        $display("FAIL restart_col[%0d] got %b want %b",
                 i, col_out, exp);
      end
      @(negedge clk);
    end
    checks++;
    if (kp.key_valid !== 1'b0) begin
      errors++;
      $display("FAIL cnt_cleared got %b want 0", kp.key_valid);
    end
    scan(K01);
    checks++;
    if (kp.key_valid !== 1'b1 || kp.key_code !== 4'b0001) begin
      errors++;
      $display("FAIL after_rst got %b/%b want 1/0001",
               kp.key_valid, kp.key_code);
    end
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    rises        = 0;
    rst_n        = 1'b0;
    keys         = '0;
    kp.key_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_bounce();
    test_multi();
    test_overrun();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
